// File: rtl/proj_truth_table_driver.sv
`timescale 1ns/1ps
// proj_truth_table_driver
//
// Sequential harness for a single-output combinational projection. It sweeps
// every input vector 0..2^N_IN-1 onto x. For each vector it waits LAT cycles
// and then samples y. The samples are packed into WORD_W-bit truth-table words,
// and each complete word is emitted on a valid/ready stream.
//
// Parameters
//   N_IN    projection input count
//   LAT     cycles between driving x and sampling y (0 = same-cycle sample)
//   WORD_W  truth-table word width, power of 2, <= 2^N_IN
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   start     in   begin a sweep (honoured only when idle)
//   busy      out  sweep in progress
//   done      out  one-cycle pulse at sweep completion
//   x         out  vector driven to the projection
//   y         in   projection response
//   tt_data   out  truth-table word; bit k of word j = y(j*WORD_W+k)
//   tt_valid  out  tt_data valid
//   tt_ready  in   sink accepts the word
//   tt_last   out  current word is the final one
//
// Optional feature, macro PROJ_SIG_EN:
//   sig       out  32-bit MISR signature over all y samples
//   sig_valid out  signature final, from the DONE cycle until next start/rst
module proj_truth_table_driver #(
  parameter int N_IN   = 10,
  parameter int LAT    = 0,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N_IN-1:0]   x,
  input  logic              y,
  output logic [WORD_W-1:0] tt_data,
  output logic              tt_valid,
  input  logic              tt_ready,
  output logic              tt_last
`ifdef PROJ_SIG_EN
  ,
  output logic [31:0]       sig,
  output logic              sig_valid
`endif
);

  localparam int NUM_VEC = 1 << N_IN;
  localparam int VEC_W   = N_IN + 1;
  localparam int IDX_W   = $clog2(WORD_W);
  localparam int WAIT_W  = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    EMIT,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [WORD_W-1:0]   word_q, word_d;

  logic [IDX_W-1:0]    bit_idx;
  logic                is_last;

  assign bit_idx = vec_q[IDX_W-1:0];
  assign is_last = (vec_q == VEC_W'(NUM_VEC - 1));

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wait_d  = wait_q;
    word_d  = word_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = '0;
          wait_d  = WAIT_W'(LAT);
          word_d  = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else begin
          word_d[bit_idx] = y;
          // The last bit of a word stays on its vector so that x holds during EMIT.
          if (bit_idx == {IDX_W{1'b1}}) begin
            state_d = EMIT;
          end else begin
            vec_d  = vec_q + VEC_W'(1);
            wait_d = WAIT_W'(LAT);
          end
        end
      end
      EMIT: begin
        if (tt_ready) begin
          if (is_last) begin
            state_d = DONE;
          end else begin
            vec_d   = vec_q + VEC_W'(1);
            wait_d  = WAIT_W'(LAT);
            word_d  = '0;
            state_d = SETTLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the pre-edge values, whatever the statement order is.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      wait_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      wait_q  <= wait_d;
      word_q  <= word_d;
    end
  end

  // The outputs decode the registered state, so they stay stable while a word
  // is stalled. tt_data is masked outside EMIT so that partial words never show.
  assign x        = vec_q[N_IN-1:0];
  assign busy     = (state_q == SETTLE) || (state_q == EMIT);
  assign done     = (state_q == DONE);
  assign tt_valid = (state_q == EMIT);
  assign tt_last  = (state_q == EMIT) && is_last;
  assign tt_data  = (state_q == EMIT) ? word_q : '0;

`ifdef PROJ_SIG_EN
  localparam logic [31:0] MISR_POLY = 32'h80200003;

  logic        sample;
  logic        finish;
  logic [31:0] sig_q, sig_d;
  logic        sig_valid_q, sig_valid_d;

  assign sample = (state_q == SETTLE) && (wait_q == '0);
  assign finish = (state_q == EMIT) && tt_ready && is_last;

  always_comb begin
    sig_d       = sig_q;
    sig_valid_d = sig_valid_q;
    if (state_q == IDLE && start) begin
      sig_d       = 32'hFFFF_FFFF;
      sig_valid_d = 1'b0;
    end else if (sample) begin
      sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ {31'b0, y};
    end else if (finish) begin
      sig_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q       <= '0;
      sig_valid_q <= 1'b0;
    end else begin
      sig_q       <= sig_d;
      sig_valid_q <= sig_valid_d;
    end
  end

  assign sig       = sig_q;
  assign sig_valid = sig_valid_q;
`endif

endmodule

// File: tb/tb_proj_truth_table_driver.sv
`timescale 1ns/1ps
// Testbench for proj_truth_table_driver.
//
// It uses two instances:
//   dut      default parameters; y comes from a selectable function of x
//            (constant 0, x[0], x[5] or a random lookup table).
//   dut_lat  LAT=2; y is a two-cycle delayed copy of x[0].
//
// Expected words, timing and signatures come from a behavioural model of the
// sweep: word j bit k = f(j*32+k), and each word takes 32*(LAT+1)+1 cycles.
// Define PROJ_SIG_EN to also check the MISR signature.
module tb_proj_truth_table_driver;

  localparam int N_IN   = 10;
  localparam int WORD_W = 32;
  localparam int NUM_VEC   = 1 << N_IN;
  localparam int NUM_WORDS = NUM_VEC / WORD_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic        tt_ready;
  int          mode;
  logic [NUM_VEC-1:0] tbl;

  logic              busy, done, tt_valid, tt_last, y;
  logic [N_IN-1:0]   x;
  logic [WORD_W-1:0] tt_data;

  logic              busy2, done2, tt_valid2, tt_last2, y2;
  logic [N_IN-1:0]   x2;
  logic [WORD_W-1:0] tt_data2;
  logic              dly1 = 1'b0, dly2 = 1'b0;

`ifdef PROJ_SIG_EN
  logic [31:0] sig, sig2;
  logic        sig_valid, sig_valid2;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  proj_truth_table_driver dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .x        (x),
    .y        (y),
    .tt_data  (tt_data),
    .tt_valid (tt_valid),
    .tt_ready (tt_ready),
    .tt_last  (tt_last)
`ifdef PROJ_SIG_EN
    ,
    .sig      (sig),
    .sig_valid(sig_valid)
`endif
  );

  proj_truth_table_driver #(.N_IN(N_IN), .LAT(2), .WORD_W(WORD_W)) dut_lat (
    .clk      (clk),
    .rst      (rst),
    .start    (start2),
    .busy     (busy2),
    .done     (done2),
    .x        (x2),
    .y        (y2),
    .tt_data  (tt_data2),
    .tt_valid (tt_valid2),
    .tt_ready (1'b1),
    .tt_last  (tt_last2)
`ifdef PROJ_SIG_EN
    ,
    .sig      (sig2),
    .sig_valid(sig_valid2)
`endif
  );

  // Reference projection for the default instance.
  function automatic logic model_y(input int m, input int v);
    logic [N_IN-1:0] vb;
    vb = N_IN'(v);
    case (m)
      1:       return vb[0];
      2:       return vb[5];
      3:       return tbl[vb];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] exp_word(input int m, input int j);
    logic [WORD_W-1:0] w;
    for (int k = 0; k < WORD_W; k++) w[k] = model_y(m, j * WORD_W + k);
    return w;
  endfunction

  function automatic logic [31:0] misr_model(input int m);
    logic [31:0] s;
    s = 32'hFFFF_FFFF;
    for (int v = 0; v < NUM_VEC; v++)
      s = (s << 1) ^ (s[31] ? 32'h80200003 : 32'h0) ^ {31'b0, model_y(m, v)};
    return s;
  endfunction

  always_comb y = model_y(mode, int'(x));

  always @(posedge clk) begin
    dly1 <= x2[0];
    dly2 <= dly1;
  end
  assign y2 = dly2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full sweep on the default instance. A stall_word >= 0 holds tt_ready
  // low for ten cycles while that word is offered.
  task automatic sweep(input int m, input bit rnd_ready, input int stall_word);
    int  n, j, stalls;
    bit  hs, rdy;
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    n = 1; j = 0; stalls = 0; hs = 0;
    while (!done && n < 6000) begin
      if (hs) begin
        check("next_word_x", x, j * WORD_W);
        check("next_word_valid_low", tt_valid, 0);
        hs = 0;
      end
      if (tt_valid && j == stall_word && stalls < 10) begin
        rdy = 1'b0;
        stalls++;
      end else begin
        rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (tt_valid) begin
        check("tt_data", tt_data, exp_word(m, j));
        check("tt_last", tt_last, (j == NUM_WORDS - 1) ? 1 : 0);
        check("emit_x", x, j * WORD_W + WORD_W - 1);
        check("emit_busy", busy, 1);
        if (rdy) begin
          j++;
          hs = (j < NUM_WORDS);
        end
      end
      tt_ready = rdy;
      tick();
      n++;
    end
    tt_ready = 1'b1;
    check("done_seen", done, 1);
    check("word_count", j, NUM_WORDS);
    check("busy_in_done", busy, 0);
    if (!rnd_ready)
      check("sweep_cycles", n, NUM_VEC + NUM_WORDS + 1 + stalls);
`ifdef PROJ_SIG_EN
    check("sig_valid_done", sig_valid, 1);
    check("sig", sig, misr_model(m));
`endif
    tick();
    check("done_pulse_end", done, 0);
    check("busy_after", busy, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_x"}, x, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, tt_valid, 0);
    check({tag, "_data"}, tt_data, 0);
    check({tag, "_last"}, tt_last, 0);
`ifdef PROJ_SIG_EN
    check({tag, "_sig"}, sig, 0);
    check({tag, "_sig_valid"}, sig_valid, 0);
`endif
  endtask

  task automatic lat_sweep();
    int n, w, off;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 1;
    while (!done2 && n < 6000) begin
      w   = (n - 1) / (WORD_W * 3 + 1);
      off = (n - 1) % (WORD_W * 3 + 1);
      if (w < NUM_WORDS) begin
        if (off < WORD_W * 3) begin
          check("lat_x", x2, w * WORD_W + off / 3);
          check("lat_valid_low", tt_valid2, 0);
        end else begin
          check("lat_valid", tt_valid2, 1);
          check("lat_data", tt_data2, 32'hAAAA_AAAA);
          check("lat_emit_x", x2, w * WORD_W + WORD_W - 1);
        end
      end
      tick();
      n++;
    end
    check("lat_done_seen", done2, 1);
    check("lat_cycles", n, NUM_VEC * 3 + NUM_WORDS + 1);
`ifdef PROJ_SIG_EN
    check("lat_sig_valid", sig_valid2, 1);
    check("lat_sig", sig2, misr_model(1));
`endif
    tick();
    check("lat_busy_after", busy2, 0);
  endtask

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; tt_ready = 1'b1; mode = 0;
    tbl = '0;
    tick();
    tick();
    check_reset_state("reset");
    check("reset_lat_busy", busy2, 0);
    check("reset_lat_valid", tt_valid2, 0);
    rst = 1'b0;
    tick();

    sweep(0, 1'b0, -1);          // y = 0
    sweep(1, 1'b0, -1);          // y = x[0]
    sweep(2, 1'b0, 3);           // y = x[5], stall on word 3
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_VEC; i++) tbl[i] = 1'($urandom_range(0, 1));
      sweep(3, 1'b1, -1);        // random table, random back-pressure
    end

    // Abort mid-sweep at vector 500.
    mode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (x != 10'd500 && guard < 2000) begin
      tick();
      guard++;
    end
    check("reached_vec_500", x, 500);
    rst = 1'b1;
    tick();
    check_reset_state("midrst");
    rst = 1'b0;
    tick();
    check("idle_after_rst", busy, 0);
    sweep(1, 1'b0, -1);

    lat_sweep();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
